// File: rtl/avmm_rw_arbiter_2to1.sv
// -----------------------------------------------------------------------------
// avmm_rw_arbiter_2to1
//
// Two-requester round-robin arbiter in front of a single fixed-latency Avalon-MM
// slave port. The slave has no waitrequest and returns reads at a fixed latency.
// One read or write is granted per cycle. The granted command passes to the
// slave in the same cycle through a zero-latency mux. A READ_LATENCY-deep tag
// pipe records which requester owns each read in flight. The pipe output steers
// readdatavalid back to that requester when the slave data arrives.
//
// Ports
//   clock, resetn            clock and asynchronous active-low reset
//   mN_address/byteenable/   requester N command (N = 0,1); a requester whose
//   read/write/writedata     waitrequest is high holds its command stable
//   mN_waitrequest           high: requester N command not accepted this cycle
//   mN_readdata              broadcast of s_readdata
//   mN_readdatavalid         mN_readdata carries requester N's read return
//   s_address/byteenable/    command to the slave; all zero on an idle cycle
//   read/write/writedata
//   s_readdata               read data from the slave, READ_LATENCY after s_read
//   err_both                 sticky: some requester raised read and write
//                            together (treated as a write, read dropped)
// -----------------------------------------------------------------------------
module avmm_rw_arbiter_2to1 #(
   parameter int ADDR_W       = 64,
   parameter int DATA_W       = 64,
   parameter int BE_W         = 8,
   parameter int READ_LATENCY = 1
) (
   input  logic              clock,
   input  logic              resetn,

   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,

   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,

   output logic [ADDR_W-1:0] s_address,
   output logic [BE_W-1:0]   s_byteenable,
   output logic              s_read,
   output logic              s_write,
   output logic [DATA_W-1:0] s_writedata,
   input  logic [DATA_W-1:0] s_readdata,

   output logic              err_both
);

   typedef struct packed {
      logic valid;   // slot holds a read issued to the slave
      logic owner;   // requester index that issued it
   } rd_tag_t;

   logic    req0, req1;
   logic    grant_valid;
   logic    grant_idx;
   logic    last_grant;
   logic    sel_read, sel_write;
   rd_tag_t pipe [READ_LATENCY];

   // Arbitration: a lone requester wins outright. On contention, the requester
   // that did not win last time wins. No grant is issued while reset is held,
   // so the slave sees no command during reset.
   always_comb begin
      // NOTE: every output of this block gets a default first. Any path that
      //       would leave a signal unassigned would otherwise infer a latch.
      req0        = m0_read | m0_write;
      req1        = m1_read | m1_write;
      grant_valid = resetn & (req0 | req1);
      grant_idx   = 1'b0;
      if (req0 & req1) grant_idx = ~last_grant;
      else if (req1)   grant_idx = 1'b1;
   end

   // Zero-latency command mux. A read+write request is issued as a write only.
   always_comb begin
      sel_read     = grant_idx ? m1_read  : m0_read;
      sel_write    = grant_idx ? m1_write : m0_write;
      s_read       = grant_valid & sel_read & ~sel_write;
      s_write      = grant_valid & sel_write;
      s_address    = '0;
      s_byteenable = '0;
      s_writedata  = '0;
      if (grant_valid) begin
         s_address    = grant_idx ? m1_address    : m0_address;
         s_byteenable = grant_idx ? m1_byteenable : m0_byteenable;
         s_writedata  = grant_idx ? m1_writedata  : m0_writedata;
      end
   end

   // waitrequest is forced high throughout reset. After reset it is high only
   // for a requester that is asking this cycle and was not granted.
   assign m0_waitrequest = ~resetn | (req0 & ~(grant_valid & ~grant_idx));
   assign m1_waitrequest = ~resetn | (req1 & ~(grant_valid &  grant_idx));

   assign m0_readdata = s_readdata;
   assign m1_readdata = s_readdata;

   // The tag leaving the pipe lines up with valid slave data.
   assign m0_readdatavalid = pipe[READ_LATENCY-1].valid & ~pipe[READ_LATENCY-1].owner;
   assign m1_readdatavalid = pipe[READ_LATENCY-1].valid &  pipe[READ_LATENCY-1].owner;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         last_grant <= 1'b1;
         err_both   <= 1'b0;
         // NOTE: the tag pipe is reset, unlike a plain data delay line. Reads in
         //       flight at reset must never raise readdatavalid afterwards.
         for (int i = 0; i < READ_LATENCY; i++) pipe[i] <= '0;
      end else begin
         // NOTE: state is updated with non-blocking assignments only. The shift
         //       below then reads every stage's pre-edge value, whatever the
         //       loop order.
         if (grant_valid) last_grant <= grant_idx;
         if ((m0_read & m0_write) | (m1_read & m1_write)) err_both <= 1'b1;
         pipe[0] <= '{valid: s_read, owner: grant_idx};
         for (int i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
      end
   end

endmodule

// File: tb/tb_avmm_rw_arbiter_2to1.sv
// -----------------------------------------------------------------------------
// tb_avmm_rw_arbiter_2to1
//
// Self-checking bench for avmm_rw_arbiter_2to1 with READ_LATENCY = 3.
// Inputs are driven just after the falling edge, and outputs are compared 1 ns
// later. A reference model is compared against the DUT every cycle. The model
// holds the fairness pointer, a queue of outstanding reads (due cycle and
// owner) and the sticky error flag. Scenario tasks also compare against
// fixed expected values of their own.
// -----------------------------------------------------------------------------
module tb_avmm_rw_arbiter_2to1;

   localparam int AW  = 64;
   localparam int DW  = 64;
   localparam int BW  = 8;
   localparam int LAT = 3;

   logic          clock = 1'b0;
   logic          resetn;
   logic [AW-1:0] m0_address, m1_address, s_address;
   logic [BW-1:0] m0_byteenable, m1_byteenable, s_byteenable;
   logic          m0_read, m0_write, m1_read, m1_write, s_read, s_write;
   logic [DW-1:0] m0_writedata, m1_writedata, s_writedata;
   logic [DW-1:0] m0_readdata, m1_readdata, s_readdata;
   logic          m0_waitrequest, m1_waitrequest;
   logic          m0_readdatavalid, m1_readdatavalid;
   logic          err_both;

   always #5 clock = ~clock;

   avmm_rw_arbiter_2to1 #(
      .ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .READ_LATENCY(LAT)
   ) dut (
      .clock(clock), .resetn(resetn),
      .m0_address(m0_address), .m0_byteenable(m0_byteenable),
      .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
      .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_byteenable(m1_byteenable),
      .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
      .m1_readdatavalid(m1_readdatavalid),
      .s_address(s_address), .s_byteenable(s_byteenable), .s_read(s_read),
      .s_write(s_write), .s_writedata(s_writedata), .s_readdata(s_readdata),
      .err_both(err_both)
   );

   typedef struct packed {
      logic          rd;
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [BW-1:0] be;
   } cmd_t;

   typedef struct {
      int due;
      bit owner;
   } ret_t;

   localparam cmd_t IDLE = '0;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   ret_t rq[$];
   bit   m_last   = 1'b1;
   bit   m_err    = 1'b0;
   int   exp_g;
   cmd_t c0, c1;

   function automatic cmd_t mk(input bit rd, input bit wr, input logic [AW-1:0] addr,
                               input logic [DW-1:0] data, input logic [BW-1:0] be);
      cmd_t c;
      c.rd = rd; c.wr = wr; c.addr = addr; c.data = data; c.be = be;
      return c;
   endfunction

   function automatic cmd_t rand_cmd();
      int k;
      k = $urandom_range(0, 9);
      return mk(k inside {[3:5], 9}, k inside {[6:9]}, {$urandom, $urandom},
                {$urandom, $urandom}, 8'($urandom));
   endfunction

   // Winner under the round-robin rule: -1 idle, else the requester index.
   function automatic int ref_grant(input cmd_t a, input cmd_t b, input bit last);
      bit r0, r1;
      r0 = a.rd | a.wr;
      r1 = b.rd | b.wr;
      if (r0 && r1) return last ? 0 : 1;
      if (r0) return 0;
      if (r1) return 1;
      return -1;
   endfunction

   task automatic reset_model();
      rq.delete();
      m_last = 1'b1;
      m_err  = 1'b0;
   endtask

   task automatic apply(input cmd_t a, input cmd_t b);
      c0 = a; c1 = b;
      m0_read = a.rd; m0_write = a.wr; m0_address = a.addr; m0_writedata = a.data; m0_byteenable = a.be;
      m1_read = b.rd; m1_write = b.wr; m1_address = b.addr; m1_writedata = b.data; m1_byteenable = b.be;
      s_readdata = {$urandom, $urandom};
      #1;
   endtask

   task automatic pulse_reset();
      resetn = 1'b0;
      #1;
      resetn = 1'b1;
      reset_model();
   endtask

   // Compares every output with the model, then advances the model and the clock.
   task automatic check_and_clock(input string tag);
      cmd_t       g;
      bit         er0, er1;
      logic [3:0] exp_ctl, got_ctl;
      exp_g   = ref_grant(c0, c1, m_last);
      g       = (exp_g == 1) ? c1 : (exp_g == 0) ? c0 : IDLE;
      exp_ctl = {g.rd & ~g.wr, g.wr, (c0.rd | c0.wr) && exp_g != 0, (c1.rd | c1.wr) && exp_g != 1};
      got_ctl = {s_read, s_write, m0_waitrequest, m1_waitrequest};
      checks++;
      if (got_ctl !== exp_ctl) begin
         failures++;
         $display("FAIL %s cyc=%0d rd/wr/wait0/wait1 got=%b exp=%b", tag, cyc, got_ctl, exp_ctl);
      end
      checks++;
      if ({s_address, s_byteenable, s_writedata} !== {g.addr, g.be, g.data}) begin
         failures++;
         $display("FAIL %s cyc=%0d slave cmd got=%h/%h/%h exp=%h/%h/%h", tag, cyc,
                  s_address, s_byteenable, s_writedata, g.addr, g.be, g.data);
      end
      er0 = rq.size() > 0 && rq[0].due == cyc && rq[0].owner == 1'b0;
      er1 = rq.size() > 0 && rq[0].due == cyc && rq[0].owner == 1'b1;
      checks++;
      if ({m0_readdatavalid, m1_readdatavalid} !== {er0, er1}) begin
         failures++;
         $display("FAIL %s cyc=%0d readdatavalid0/1 got=%b%b exp=%b%b", tag, cyc,
                  m0_readdatavalid, m1_readdatavalid, er0, er1);
      end
      checks++;
      if ({m0_readdata, m1_readdata} !== {s_readdata, s_readdata}) begin
         failures++;
         $display("FAIL %s cyc=%0d readdata got=%h/%h exp=%h", tag, cyc, m0_readdata, m1_readdata, s_readdata);
      end
      checks++;
      if (err_both !== m_err) begin
         failures++;
         $display("FAIL %s cyc=%0d err_both got=%b exp=%b", tag, cyc, err_both, m_err);
      end
      if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
      if (exp_g >= 0) begin
         m_last = exp_g[0];
         if (g.rd && !g.wr) rq.push_back('{cyc + LAT, exp_g[0]});
      end
      if ((c0.rd && c0.wr) || (c1.rd && c1.wr)) m_err = 1'b1;
      @(posedge clock);
      @(negedge clock);
      cyc++;
   endtask

   task automatic idle_cycles(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         apply(IDLE, IDLE);
         check_and_clock(tag);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      apply(mk(1, 0, 64'h40, '0, '1), IDLE);
      repeat (2) @(posedge clock);
      @(negedge clock);
      checks++;
      if ({s_read, s_write, m0_waitrequest, m1_waitrequest, err_both, m0_readdatavalid, m1_readdatavalid}
          !== 7'b0011000) begin
         failures++;
         $display("FAIL reset rd/wr/wait0/wait1/err/rdv0/rdv1 got=%b%b%b%b%b%b%b exp=0011000",
                  s_read, s_write, m0_waitrequest, m1_waitrequest, err_both, m0_readdatavalid, m1_readdatavalid);
      end
      checks++;
      if ({s_address, s_byteenable, s_writedata} !== '0) begin
         failures++;
         $display("FAIL reset slave cmd got=%h/%h/%h exp=0", s_address, s_byteenable, s_writedata);
      end
      apply(IDLE, IDLE);
      resetn = 1'b1;
      reset_model();
      idle_cycles(2, "reset_idle");
   endtask

   task automatic test_solo_read();
      int t0;
      apply(mk(1, 0, 64'h40, '0, 8'hFF), IDLE);
      checks++;
      if (s_read !== 1'b1 || s_address !== 64'h40) begin
         failures++;
         $display("FAIL solo_issue s_read/s_address got=%b/%h exp=1/40", s_read, s_address);
      end
      t0 = cyc;
      check_and_clock("solo");
      for (int k = 1; k <= LAT + 2; k++) begin
         apply(IDLE, IDLE);
         checks++;
         if ({m0_readdatavalid, m1_readdatavalid} !== {cyc == t0 + LAT, 1'b0}) begin
            failures++;
            $display("FAIL solo_return cyc=%0d rdv0/rdv1 got=%b%b exp=%b0", cyc,
                     m0_readdatavalid, m1_readdatavalid, cyc == t0 + LAT);
         end
         check_and_clock("solo_drain");
      end
   endtask

   task automatic test_contention();
      pulse_reset();
      for (int k = 0; k < 8; k++) begin
         if (k < 4) apply(mk(1, 0, 64'h1000, '0, '1), mk(1, 0, 64'h2000, '0, '1));
         else       apply(IDLE, IDLE);
         if (k < 4) begin
            checks++;
            if ({m0_waitrequest, m1_waitrequest} !== {k[0], ~k[0]}) begin
               failures++;
               $display("FAIL contention_grant k=%0d wait0/wait1 got=%b%b exp=%b%b", k,
                        m0_waitrequest, m1_waitrequest, k[0], ~k[0]);
            end
         end
         if (k >= 3) begin
            checks++;
            if ({m0_readdatavalid, m1_readdatavalid} !==
                ((k <= 6) ? (((k - 3) % 2 == 0) ? 2'b10 : 2'b01) : 2'b00)) begin
               failures++;
               $display("FAIL contention_owner k=%0d rdv0/rdv1 got=%b%b", k, m0_readdatavalid, m1_readdatavalid);
            end
         end
         check_and_clock("contention");
      end
   endtask

   task automatic test_mixed();
      cmd_t w0, r1;
      pulse_reset();
      w0 = mk(0, 1, 64'h100, 64'hDEAD_BEEF, 8'h0F);
      r1 = mk(1, 0, 64'h200, '0, 8'hFF);
      apply(w0, r1);
      checks++;
      if ({s_write, s_read, m1_waitrequest} !== 3'b101 || s_byteenable !== 8'h0F ||
          s_writedata !== 64'hDEAD_BEEF) begin
         failures++;
         $display("FAIL mixed_write wr/rd/wait1 got=%b%b%b be=%h data=%h exp=101 0f deadbeef",
                  s_write, s_read, m1_waitrequest, s_byteenable, s_writedata);
      end
      check_and_clock("mixed_w");
      apply(IDLE, r1);
      checks++;
      if ({s_read, m1_waitrequest} !== 2'b10 || s_address !== 64'h200) begin
         failures++;
         $display("FAIL mixed_read rd/wait1 got=%b%b addr=%h exp=10 200", s_read, m1_waitrequest, s_address);
      end
      check_and_clock("mixed_r");
      idle_cycles(LAT + 1, "mixed_drain");
   endtask

   task automatic test_illegal();
      apply(IDLE, mk(1, 1, 64'h300, 64'h55, 8'hFF));
      checks++;
      if ({s_write, s_read} !== 2'b10) begin
         failures++;
         $display("FAIL illegal_issue wr/rd got=%b%b exp=10", s_write, s_read);
      end
      check_and_clock("illegal");
      idle_cycles(LAT + 2, "illegal_hold");
      checks++;
      if (err_both !== 1'b1) begin
         failures++;
         $display("FAIL illegal_sticky err_both got=%b exp=1", err_both);
      end
      pulse_reset();
      checks++;
      if (err_both !== 1'b0) begin
         failures++;
         $display("FAIL illegal_clear err_both got=%b exp=0", err_both);
      end
   endtask

   task automatic test_reset_in_flight();
      apply(mk(1, 0, 64'h80, '0, '1), IDLE);
      check_and_clock("flight_issue");
      idle_cycles(1, "flight_wait");
      resetn = 1'b0;
      #1;
      checks++;
      if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin
         failures++;
         $display("FAIL flight_in_reset rdv got=%b%b exp=00", m0_readdatavalid, m1_readdatavalid);
      end
      resetn = 1'b1;
      reset_model();
      for (int k = 0; k < LAT + 2; k++) begin
         apply(IDLE, IDLE);
         checks++;
         if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin
            failures++;
            $display("FAIL flight_after cyc=%0d rdv got=%b%b exp=00", cyc, m0_readdatavalid, m1_readdatavalid);
         end
         check_and_clock("flight_after");
      end
   endtask

   task automatic test_random();
      cmd_t a, b;
      bit   hold0, hold1;
      pulse_reset();
      a = IDLE; b = IDLE; hold0 = 0; hold1 = 0;
      for (int k = 0; k < 400; k++) begin
         if (!hold0) a = rand_cmd();
         if (!hold1) b = rand_cmd();
         apply(a, b);
         check_and_clock("random");
         hold0 = (a.rd | a.wr) && exp_g != 0;
         hold1 = (b.rd | b.wr) && exp_g != 1;
      end
      idle_cycles(LAT + 1, "random_drain");
   endtask

   initial begin
      test_reset();
      test_solo_read();
      test_contention();
      test_mixed();
      test_illegal();
      test_reset_in_flight();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
